// File: rtl/indicator_pkg.sv
// ============================================================================
//  Module      : indicator_pkg
//  Description : Shared mode encoding and request decode for the indicator
//                flasher.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package indicator_pkg;

    // Flasher operating modes
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LEFT   = 2'b01,
        RIGHT  = 2'b10,
        HAZARD = 2'b11
    } mode_t;

    // Registered request {left_ind, right_ind} -> operating mode
    function automatic mode_t decode_req(input logic [1:0] req);
        mode_t m;
        case (req)
            2'b10:   m = LEFT;
            2'b01:   m = RIGHT;
            2'b11:   m = HAZARD;
            default: m = IDLE;
        endcase
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/flash_timer.sv
// ============================================================================
//  Module      : flash_timer
//  Description : Half-period counter producing the common flash phase.
//                Restart forces the ON phase with a fresh count; fast halves
//                the half-period and takes effect immediately.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module flash_timer #(
    parameter int HALF_PERIOD = 33_333_333,
    parameter int CNT_W       = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic run,
    input  logic fast,
    output logic phase,
    output logic toggle
);

    localparam logic [CNT_W-1:0] c_LIM_SLOW = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] c_LIM_FAST = CNT_W'((HALF_PERIOD >> 1) - 1);
    localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_lim;

    // Terminal count; >= lets a shortened limit take effect mid-phase
    assign w_lim  = fast ? c_LIM_FAST : c_LIM_SLOW;
    assign toggle = run && !restart && (r_cnt >= w_lim);

    // Counter and phase: clear when idle, force ON on restart, else count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            phase <= 1'b0;
        end else if (!run) begin
            r_cnt <= '0;
            phase <= 1'b0;
        end else if (restart) begin
            r_cnt <= '0;
            phase <= 1'b1;
        end else if (toggle) begin
            r_cnt <= '0;
            phase <= ~phase;
        end else begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

endmodule

`default_nettype wire

// File: rtl/indicator_flasher.sv
// ============================================================================
//  Module      : indicator_flasher
//  Description : Turns steady left/right indicator levels into blinking lamp
//                drives with a shared phase, a clicker tick on every lamp
//                edge and a hazard status flag. Bulb faults double the rate.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module indicator_flasher
    import indicator_pkg::*;
#(
    parameter int HALF_PERIOD = 33_333_333,
    parameter int CNT_W       = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic left_ind,
    input  logic right_ind,
    input  logic left_fault,
    input  logic right_fault,
    output logic left_lamp,
    output logic right_lamp,
    output logic tick,
    output logic hazard_active
);

    logic [1:0] r_req;
    mode_t      r_mode;
    mode_t      w_mode_d;
    logic       w_run;
    logic       w_restart;
    logic       w_fast;
    logic       w_phase;
    logic       w_toggle;
    logic       w_phase_d;
    logic       w_left_d;
    logic       w_right_d;

    // Single request register; inputs are already in this clock domain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_req <= 2'b00;
        else      r_req <= {left_ind, right_ind};
    end

    // Mode register follows the decoded request every cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_mode <= IDLE;
        else      r_mode <= w_mode_d;
    end

    // Next mode, timer control and next lamp values
    always_comb begin
        w_mode_d  = decode_req(r_req);
        w_run     = (w_mode_d != IDLE);
        w_restart = w_run && (w_mode_d != r_mode);
        w_fast    = 1'b0;
        case (w_mode_d)
            LEFT:    w_fast = left_fault;
            RIGHT:   w_fast = right_fault;
            HAZARD:  w_fast = left_fault | right_fault;
            default: w_fast = 1'b0;
        endcase
        // Phase value the timer will hold after this edge
        if (!w_run)         w_phase_d = 1'b0;
        else if (w_restart) w_phase_d = 1'b1;
        else                w_phase_d = w_phase ^ w_toggle;
        w_left_d  = w_phase_d && ((w_mode_d == LEFT)  || (w_mode_d == HAZARD));
        w_right_d = w_phase_d && ((w_mode_d == RIGHT) || (w_mode_d == HAZARD));
    end

    flash_timer #(
        .HALF_PERIOD (HALF_PERIOD),
        .CNT_W       (CNT_W)
    ) u_flash_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (w_restart),
        .run     (w_run),
        .fast    (w_fast),
        .phase   (w_phase),
        .toggle  (w_toggle)
    );

    // Registered lamp drives, one tick per lamp edge, hazard flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            left_lamp     <= 1'b0;
            right_lamp    <= 1'b0;
            tick          <= 1'b0;
            hazard_active <= 1'b0;
        end else begin
            left_lamp     <= w_left_d;
            right_lamp    <= w_right_d;
            tick          <= (w_left_d != left_lamp) || (w_right_d != right_lamp);
            hazard_active <= (w_mode_d == HAZARD);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_indicator_flasher.sv
// ============================================================================
//  Module      : tb_indicator_flasher
//  Description : Self-checking bench for indicator_flasher with a behavioural
//                lamp model and directed literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_indicator_flasher;

    localparam int HP = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic left_ind = 1'b0, right_ind = 1'b0;
    logic left_fault = 1'b0, right_fault = 1'b0;
    logic left_lamp, right_lamp, tick, hazard_active;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: mode kept as the raw {left,right} request pattern
    logic [1:0] m_req  = 2'b00;
    logic [1:0] m_mode = 2'b00;
    logic       m_phase = 1'b0;
    int         m_n = 0;           // cycles the current phase has been shown
    logic       m_left = 1'b0, m_right = 1'b0, m_tick = 1'b0, m_haz = 1'b0;
    int         cyc = -1;

    indicator_flasher #(.HALF_PERIOD(HP), .CNT_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .left_ind      (left_ind),
        .right_ind     (right_ind),
        .left_fault    (left_fault),
        .right_fault   (right_fault),
        .left_lamp     (left_lamp),
        .right_lamp    (right_lamp),
        .tick          (tick),
        .hazard_active (hazard_active)
    );

    initial forever #5 clk = ~clk;

    task automatic model_step();
        logic [1:0] nm;
        logic       f;
        int         len;
        logic       nl, nr;
        if (!rst) begin
            m_req = 2'b00; m_mode = 2'b00; m_phase = 1'b0; m_n = 0;
            m_left = 1'b0; m_right = 1'b0; m_tick = 1'b0; m_haz = 1'b0;
            cyc = -1;
            return;
        end
        nm = m_req;
        f  = (nm[1] & left_fault) | (nm[0] & right_fault);
        if (nm == 2'b00) begin
            m_phase = 1'b0; m_n = 0;
        end else if (nm != m_mode) begin
            m_phase = 1'b1; m_n = 1;
        end else begin
            len = f ? HP / 2 : HP;
            if (m_n >= len) begin
                m_phase = ~m_phase; m_n = 1;
            end else begin
                m_n = m_n + 1;
            end
        end
        nl = nm[1] & m_phase;
        nr = nm[0] & m_phase;
        m_tick  = (nl != m_left) || (nr != m_right);
        m_left  = nl;
        m_right = nr;
        m_haz   = (nm == 2'b11);
        m_mode  = nm;
        m_req   = {left_ind, right_ind};
        cyc     = cyc + 1;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison against the model while out of reset
    initial forever begin
        @(negedge clk);
        if (rst) begin
            n_tests++;
            if ({left_lamp, right_lamp, tick, hazard_active} !==
                {m_left, m_right, m_tick, m_haz}) begin
                n_fail++;
                $display("FAIL model_cmp cyc=%0d got l=%b r=%b t=%b h=%b expected l=%b r=%b t=%b h=%b",
                         cyc, left_lamp, right_lamp, tick, hazard_active,
                         m_left, m_right, m_tick, m_haz);
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
        end
    endtask

    logic ll [0:22];
    logic rl [0:22];
    logic tk [0:22];

    initial begin
        int tsum, rsum;
        bit found;

        repeat (3) @(negedge clk);
        check("reset_left_lamp",  {31'd0, left_lamp},     0);
        check("reset_right_lamp", {31'd0, right_lamp},    0);
        check("reset_tick",       {31'd0, tick},          0);
        check("reset_hazard",     {31'd0, hazard_active}, 0);

        // Steady LEFT from cycle 0
        left_ind = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            ll[i] = left_lamp; rl[i] = right_lamp; tk[i] = tick;
        end
        check("left_c0",  {31'd0, ll[0]},  0);
        check("left_c1",  {31'd0, ll[1]},  1);
        check("left_c10", {31'd0, ll[10]}, 1);
        check("left_c11", {31'd0, ll[11]}, 0);
        check("left_c20", {31'd0, ll[20]}, 0);
        check("left_c21", {31'd0, ll[21]}, 1);
        tsum = 0; rsum = 0;
        for (int i = 0; i < 23; i++) begin
            tsum += int'(tk[i]);
            rsum += int'(rl[i]);
        end
        check("left_tick_count", tsum, 3);
        check("left_tick_c1_11_21", {29'd0, tk[1], tk[11], tk[21]}, 7);
        check("left_right_lamp_off", rsum, 0);

        // Hazard: both in phase, flag raised
        right_ind = 1'b1;
        repeat (15) @(negedge clk);
        check("hazard_flag", {31'd0, hazard_active}, 1);
        check("hazard_in_phase", {31'd0, left_lamp}, {31'd0, right_lamp});

        // Randomised requests and faults
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0) {left_ind, right_ind} = 2'($urandom);
            if ($urandom_range(0, 14) == 0) left_fault  = 1'($urandom);
            if ($urandom_range(0, 14) == 0) right_fault = 1'($urandom);
        end

        // Asynchronous reset while a lamp is on
        {left_ind, right_ind} = 2'b10;
        left_fault = 1'b0; right_fault = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (left_lamp) found = 1'b1;
        end
        check("wait_left_on", {31'd0, found}, 1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_left_lamp",  {31'd0, left_lamp},     0);
        check("async_right_lamp", {31'd0, right_lamp},    0);
        check("async_tick",       {31'd0, tick},          0);
        check("async_hazard",     {31'd0, hazard_active}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rerelease_c0", {31'd0, left_lamp}, 0);
        @(negedge clk);
        check("rerelease_c1", {31'd0, left_lamp}, 1);
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
